// File: rtl/morph_pkg.sv
// Shared types for the morphological frame controller: FSM states and op select.
package morph_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        FIN   = 3'd4
    } state_e;

    typedef enum logic {
        OP_DILATE = 1'b0,
        OP_ERODE  = 1'b1
    } op_e;

    localparam int unsigned ROM_LAT_MAX = 4;

endpackage

// File: rtl/morph_frame_ctrl_if.sv
// Control bus between the frame controller and its start/mode source, ROM/RAM and window datapath.
interface morph_frame_ctrl_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              start;
    logic              abort;
    logic              switch1;
    logic              read_request;
    logic [ADDR_W-1:0] romaddress;
    logic              win_clear;
    logic              win_shift;
    logic              win_zero;
    logic              win_mode;
    logic              write_enable;
    logic [ADDR_W-1:0] ramaddress;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, switch1,
        output read_request, romaddress, win_clear, win_shift, win_zero, win_mode,
        output write_enable, ramaddress, busy, done
    );

    modport slave (
        output start, abort, switch1,
        input  read_request, romaddress, win_clear, win_shift, win_zero, win_mode,
        input  write_enable, ramaddress, busy, done
    );
endinterface

// File: rtl/morph_lat_pipe.sv
// DEPTH-deep valid/zero-flag delay line matching the ROM read latency; flushed on clear.
module morph_lat_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic valid_i,
    input  logic zero_i,
    output logic valid_o,
    output logic zero_o
);
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] zero_q,  zero_d;

    // Shift toward the MSB; the dropped top bit is the one already presented at the output.
    always_comb begin
        valid_d = DEPTH'({valid_q, valid_i});
        zero_d  = DEPTH'({zero_q,  zero_i});
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= '0;
            zero_q  <= '0;
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign zero_o  = zero_q[DEPTH-1];
endmodule

// File: rtl/morph_frame_ctrl.sv
// Sequences one 3-row erode/dilate pass: ROM row reads, window shifts with a zero bottom
// border row, and one RAM write per finished output row.
module morph_frame_ctrl
    import morph_pkg::*;
#(
    parameter int unsigned ROWS    = 48,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    morph_frame_ctrl_if.master bus
);
    if (ROWS < 1 || ROWS > (2 ** ADDR_W) - 1) begin : g_rows_chk
        $fatal(1, "morph_frame_ctrl: ROWS must be in 1..2**ADDR_W-1");
    end
    if (ROM_LAT < 1 || ROM_LAT > ROM_LAT_MAX) begin : g_lat_chk
        $fatal(1, "morph_frame_ctrl: ROM_LAT must be in 1..4");
    end

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    state_e            state_q;
    op_e               mode_q;
    logic              rd_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              clear_q;
    logic              zero_tag_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] row_q;
    logic              wr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              shift;
    logic              shift_zero;
    logic              abort_act;
    logic              start_acc;

    assign abort_act = bus.abort && (state_q != IDLE);
    assign start_acc = bus.start && (state_q == IDLE);

    // Main sequencer; the zero tag rides the latency pipe one slot behind the last read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= OP_DILATE;
            rd_q       <= 1'b0;
            rom_addr_q <= '0;
            clear_q    <= 1'b0;
            zero_tag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort_act) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            clear_q    <= 1'b0;
            zero_tag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            clear_q    <= 1'b0;
            zero_tag_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= ISSUE;
                        mode_q     <= op_e'(bus.switch1);
                        clear_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        rd_q       <= 1'b1;
                        rom_addr_q <= '0;
                    end
                end
                ISSUE: begin
                    if (rom_addr_q == LAST_ROW) begin
                        rd_q       <= 1'b0;
                        zero_tag_q <= 1'b1;
                        state_q    <= DRAIN;
                    end else begin
                        rom_addr_q <= rom_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (shift && row_q == LAST_ROW) state_q <= FLUSH;
                end
                FLUSH: state_q <= FIN;
                FIN: begin
                    if (wr_q && ram_addr_q == LAST_ROW) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    morph_lat_pipe #(
        .DEPTH (ROM_LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .clear_i (abort_act),
        .valid_i (rd_q | zero_tag_q),
        .zero_i  (zero_tag_q),
        .valid_o (shift),
        .zero_o  (shift_zero)
    );

    // Write stage: the shift that completes a window of rows k-2..k writes row k-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= '0;
            wr_q       <= 1'b0;
            ram_addr_q <= '0;
        end else if (abort_act) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= shift && (row_q != '0);
            if (shift) begin
                row_q <= row_q + ADDR_W'(1);
                if (row_q != '0) ram_addr_q <= row_q - ADDR_W'(1);
            end
            if (start_acc) row_q <= '0;
        end
    end

    assign bus.read_request = rd_q;
    assign bus.romaddress   = rom_addr_q;
    assign bus.win_clear    = clear_q;
    assign bus.win_shift    = shift;
    assign bus.win_zero     = shift_zero;
    assign bus.win_mode     = mode_q;
    assign bus.write_enable = wr_q;
    assign bus.ramaddress   = ram_addr_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Bench for morph_frame_ctrl: ROM + 3-line window model with a write scoreboard (48 rows, L=1)
// and a cycle-exact timing table for a short 4-row, L=3 instance.
module tb_morph_frame_ctrl;
    localparam int unsigned ROWS_A = 48;
    localparam int unsigned LAT_A  = 1;
    localparam int unsigned ROWS_B = 4;
    localparam int unsigned LAT_B  = 3;
    localparam int unsigned AW     = 7;
    localparam int unsigned PW     = 16;

    typedef struct {
        int            addr;
        logic [PW-1:0] data;
        int            cyc;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    morph_frame_ctrl_if #(.ADDR_W(AW)) ifa ();
    morph_frame_ctrl_if #(.ADDR_W(AW)) ifb ();

    morph_frame_ctrl #(.ROWS(ROWS_A), .ADDR_W(AW), .ROM_LAT(LAT_A)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    morph_frame_ctrl #(.ROWS(ROWS_B), .ADDR_W(AW), .ROM_LAT(LAT_B)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    logic [PW-1:0] img [128];
    logic [PW-1:0] rom_q, ln0, ln1, ln2;
    wr_exp_t       sb [$];
    int            base, rd_next, wr_cnt, done_cnt, exp_done_cyc;
    bit            exp_done_vld = 1'b0;
    logic          exp_mode;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic logic [PW-1:0] img_at(input int r);
        if (r < 0 || r >= int'(ROWS_A)) return '0;
        return img[7'(r)];
    endfunction

    function automatic logic [PW-1:0] golden_row(input int r, input logic erode);
        logic [PW-1:0] c, u, d;
        c = img_at(r);
        u = img_at(r - 1);
        d = img_at(r + 1);
        if (erode) return c & u & d & (c << 1) & (c >> 1);
        return c | u | d | (c << 1) | (c >> 1);
    endfunction

    // Hand-derived dilation of a single pixel at row 10, bit 5.
    function automatic logic [PW-1:0] plus_row(input int r);
        if (r == 9 || r == 11) return 16'h0020;
        if (r == 10) return 16'h0070;
        return 16'h0000;
    endfunction

    // ROM with one cycle of latency plus the window line registers.
    always @(posedge clk) begin
        if (ifa.read_request) rom_q <= img[ifa.romaddress];
        if (ifa.win_clear) begin
            ln0 <= '0;
            ln1 <= '0;
            ln2 <= '0;
        end else if (ifa.win_shift) begin
            ln0 <= ln1;
            ln1 <= ln2;
            ln2 <= ifa.win_zero ? '0 : rom_q;
        end
    end

    always @(negedge clk) begin
        wr_exp_t       e;
        logic [PW-1:0] got;
        if (ifa.read_request === 1'b1) begin
            check_eq("rd_addr", 32'(ifa.romaddress), rd_next);
            check_eq("rd_cyc", cyc, base + 1 + rd_next);
            rd_next++;
        end
        if (ifa.write_enable === 1'b1) begin
            wr_cnt++;
            got = ifa.win_mode ? (ln1 & ln0 & ln2 & (ln1 << 1) & (ln1 >> 1))
                               : (ln1 | ln0 | ln2 | (ln1 << 1) | (ln1 >> 1));
            if (sb.size() == 0) begin
                check_eq("wr_unexpected", 32'(ifa.ramaddress), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_eq("wr_addr", 32'(ifa.ramaddress), e.addr);
                check_eq("wr_data", 32'(got), 32'(e.data));
                check_eq("wr_cyc", cyc, e.cyc);
                check_eq("wr_mode", 32'(ifa.win_mode), 32'(exp_mode));
            end
        end
        if (ifa.done === 1'b1) begin
            done_cnt++;
            check_eq("done_cyc", cyc, exp_done_vld ? exp_done_cyc : -1);
            exp_done_vld = 1'b0;
        end
    end

    task automatic start_a(input logic sw, input logic with_abort, input bit hand);
        wr_exp_t e;
        @(negedge clk);
        base        = cyc;
        rd_next     = 0;
        wr_cnt      = 0;
        done_cnt    = 0;
        exp_mode    = sw;
        ifa.start   = 1'b1;
        ifa.switch1 = sw;
        ifa.abort   = with_abort;
        for (int r = 0; r < int'(ROWS_A); r++) begin
            e.addr = r;
            e.data = hand ? plus_row(r) : golden_row(r, sw);
            e.cyc  = base + 3 + int'(LAT_A) + r;
            sb.push_back(e);
        end
        exp_done_cyc = base + 3 + int'(LAT_A) + int'(ROWS_A);
        exp_done_vld = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
    endtask

    task automatic wait_pass(input string tag);
        int n = 0;
        while (exp_done_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_timeout"}, 32'(exp_done_vld), 32'd0);
        @(negedge clk);
        check_eq({tag, "_wr_cnt"}, wr_cnt, ROWS_A);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_sb_left"}, sb.size(), 0);
        check_eq({tag, "_busy"}, 32'(ifa.busy), 32'd0);
    endtask

    task automatic fill_random();
        for (int r = 0; r < int'(ROWS_A); r++) img[7'(r)] = PW'($urandom | $urandom);
    endtask

    task automatic check_a_quiet(input string tag);
        check_eq({tag, "_rd"}, 32'(ifa.read_request), 32'd0);
        check_eq({tag, "_shift"}, 32'(ifa.win_shift), 32'd0);
        check_eq({tag, "_wr"}, 32'(ifa.write_enable), 32'd0);
        check_eq({tag, "_busy"}, 32'(ifa.busy), 32'd0);
        check_eq({tag, "_done"}, 32'(ifa.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.switch1 = 1'b0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.switch1 = 1'b0;
        for (int r = 0; r < 128; r++) img[r] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_a_quiet("reset");
        check_eq("reset_clear", 32'(ifa.win_clear), 32'd0);
        check_eq("reset_zero", 32'(ifa.win_zero), 32'd0);
        check_eq("reset_mode", 32'(ifa.win_mode), 32'd0);
        check_eq("reset_romaddr", 32'(ifa.romaddress), 32'd0);
        check_eq("reset_ramaddr", 32'(ifa.ramaddress), 32'd0);
        rst = 1'b0;

        // Erode over a dense random frame.
        fill_random();
        start_a(1'b1, 1'b0, 1'b0);
        wait_pass("t1");

        // Dilate of a single pixel; switch1 toggles mid-pass and must not affect the mode.
        for (int r = 0; r < int'(ROWS_A); r++) img[7'(r)] = '0;
        img[10] = 16'h0020;
        start_a(1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        ifa.switch1 = 1'b1;
        repeat (10) @(negedge clk);
        ifa.switch1 = 1'b0;
        repeat (5) @(negedge clk);
        ifa.switch1 = 1'b1;
        wait_pass("t2");
        check_eq("t2_win_mode", 32'(ifa.win_mode), 32'd0);

        // Start re-pulsed at cycles 10 and 30 of a running pass.
        fill_random();
        start_a(1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (19) @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_pass("t3");

        // Abort at cycle 20, then a fresh pass started at cycle 25.
        fill_random();
        start_a(1'b1, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        ifa.abort = 1'b1;
        @(posedge clk);
        #1;
        ifa.abort = 1'b0;
        sb.delete();
        exp_done_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_a_quiet($sformatf("t4_after_abort_%0d", i));
        end
        check_eq("t4_wr_before_abort", wr_cnt, 17);
        check_eq("t4_done_after_abort", done_cnt, 0);
        start_a(1'b0, 1'b0, 1'b0);
        wait_pass("t4b");

        // Reset at cycle 15 of a pass; restart with start and abort together in IDLE.
        fill_random();
        start_a(1'b1, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_done_vld = 1'b0;
        @(negedge clk);
        check_a_quiet("t5_after_rst");
        check_eq("t5_clear", 32'(ifa.win_clear), 32'd0);
        check_eq("t5_zero", 32'(ifa.win_zero), 32'd0);
        check_eq("t5_mode", 32'(ifa.win_mode), 32'd0);
        check_eq("t5_romaddr", 32'(ifa.romaddress), 32'd0);
        check_eq("t5_ramaddr", 32'(ifa.ramaddress), 32'd0);
        start_a(1'b1, 1'b1, 1'b0);
        wait_pass("t5b");

        // Cycle table for ROWS=4, L=3.
        @(negedge clk);
        ifb.start   = 1'b1;
        ifb.switch1 = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            if (n > 1) @(negedge clk);
            check_eq($sformatf("t6_rd_c%0d", n), 32'(ifb.read_request), 32'(n >= 1 && n <= 4));
            if (n <= 4) check_eq($sformatf("t6_romaddr_c%0d", n), 32'(ifb.romaddress), n - 1);
            check_eq($sformatf("t6_clear_c%0d", n), 32'(ifb.win_clear), 32'(n == 1));
            check_eq($sformatf("t6_shift_c%0d", n), 32'(ifb.win_shift), 32'(n >= 4 && n <= 8));
            check_eq($sformatf("t6_zero_c%0d", n), 32'(ifb.win_zero), 32'(n == 8));
            check_eq($sformatf("t6_wr_c%0d", n), 32'(ifb.write_enable), 32'(n >= 6 && n <= 9));
            if (n >= 6 && n <= 9)
                check_eq($sformatf("t6_ramaddr_c%0d", n), 32'(ifb.ramaddress), n - 6);
            check_eq($sformatf("t6_done_c%0d", n), 32'(ifb.done), 32'(n == 10));
            check_eq($sformatf("t6_busy_c%0d", n), 32'(ifb.busy), 32'(n >= 1 && n <= 9));
        end
        check_eq("t6_mode", 32'(ifb.win_mode), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
